// File: rtl/rot_share_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rot_share_pkg: shared types for the rotator share arbiter | Rev 1.0
// ----------------------------------------------------------------------------
package rot_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rot_left_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rot_left_core: combinational log2(DATA_W)-stage rotate-left | Rev 1.0
// ----------------------------------------------------------------------------
module rot_left_core #(
   parameter  int DATA_W = 8,
   localparam int AMT_W  = $clog2(DATA_W)
) (
   input  logic [DATA_W-1:0] a,
   input  logic [AMT_W-1:0]  amt,
   output logic [DATA_W-1:0] y
);

   logic [DATA_W-1:0] stage_val;

   // Stage s rotates by 2**s when amt[s] is set; the loop unrolls into a barrel.
   always_comb begin
      stage_val = a;
      for (int s = 0; s < AMT_W; s++) begin
         if (amt[s]) begin
            stage_val = (stage_val << (1 << s)) | (stage_val >> (DATA_W - (1 << s)));
         end
      end
      y = stage_val;
   end

endmodule
`default_nettype wire

// File: rtl/rotator_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rotator_share_arbiter: round-robin share of one rotator by two requesters | Rev 1.0
// ----------------------------------------------------------------------------
module rotator_share_arbiter
   import rot_share_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int AMT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [AMT_W-1:0]  req0_amt,
   input  logic              req0_dir,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [AMT_W-1:0]  req1_amt,
   input  logic              req1_dir,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_id
);

   state_t            state;
   state_t            state_nx;
   logic              rr_ptr;
   logic              any_valid;
   logic              gnt_id;
   logic              accept;
   logic [DATA_W-1:0] cap_data;
   logic [AMT_W-1:0]  cap_amt;
   logic              cap_dir;
   logic              cap_id;
   logic [AMT_W-1:0]  eff_amt;
   logic [DATA_W-1:0] rot_y;

   // Ready is held low while reset is asserted so no requester sees a phantom transfer.
   always_comb begin
      any_valid  = req0_valid | req1_valid;
      gnt_id     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
      accept     = (state == IDLE) & any_valid & ~reset;
      req0_ready = accept & ~gnt_id;
      req1_ready = accept & gnt_id;

      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A right rotate by n equals a left rotate by (DATA_W - n) mod DATA_W, i.e. -n in AMT_W bits.
   always_comb begin
      eff_amt = cap_amt;
      case (cap_dir)
         DIR_LEFT:  eff_amt = cap_amt;
         DIR_RIGHT: eff_amt = (~cap_amt) + AMT_W'(1);
         default:   eff_amt = cap_amt;
      endcase
   end

   rot_left_core #(
      .DATA_W (DATA_W)
   ) u_rot_left_core (
      .a   (cap_data),
      .amt (eff_amt),
      .y   (rot_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= 1'b0;
         cap_data   <= '0;
         cap_amt    <= '0;
         cap_dir    <= 1'b0;
         cap_id     <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
      end else begin
         if (accept) begin
            cap_data <= gnt_id ? req1_data : req0_data;
            cap_amt  <= gnt_id ? req1_amt  : req0_amt;
            cap_dir  <= gnt_id ? req1_dir  : req0_dir;
            cap_id   <= gnt_id;
         end
         if (state == EXEC) begin
            resp_data  <= rot_y;
            resp_id    <= cap_id;
            resp_valid <= 1'b1;
         end
         if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= ~resp_id;
         end
      end
   end

   // A pending request must keep valid and payload steady until it is accepted.
   a_req0_hold : assert property (@(posedge clk) disable iff (reset)
      (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_data)
                                       && $stable(req0_amt) && $stable(req0_dir)));
   a_req1_hold : assert property (@(posedge clk) disable iff (reset)
      (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_data)
                                       && $stable(req1_amt) && $stable(req1_dir)));

endmodule
`default_nettype wire

// File: tb/tb_rotator_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rotator_share_arbiter: scoreboard bench for the rotator share arbiter | Rev 1.0
// ----------------------------------------------------------------------------
module tb_rotator_share_arbiter;

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic       dir;
      logic [7:0] exp;
   } req_t;

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         cyc;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0;
   logic       req0_ready;
   logic [7:0] req0_data = '0;
   logic [2:0] req0_amt = '0;
   logic       req0_dir = 1'b0;
   logic       req1_valid = 1'b0;
   logic       req1_ready;
   logic [7:0] req1_data = '0;
   logic [2:0] req1_amt = '0;
   logic       req1_dir = 1'b0;
   logic       resp_valid;
   logic       resp_ready = 1'b1;
   logic [7:0] resp_data;
   logic       resp_id;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   req_t q0[$];
   req_t q1[$];
   sb_t  sb[$];
   logic acc_log[$];
   logic in_resp = 1'b0;
   logic [7:0] held_d;
   logic       held_id;

   rotator_share_arbiter #(.DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req0_dir   (req0_dir),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .req1_dir   (req1_dir),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_rot(input logic [7:0] d, input int a, input logic dir);
      logic [15:0] w;
      logic [15:0] t;
      w = {d, d};
      t = dir ? (w >> a) : (w << a);
      return dir ? t[7:0] : t[15:8];
   endfunction

   // Requester 0 driver: presents queue head, logs expectation on transfer.
   initial forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
         req0_valid = 1'b1;
         req0_data  = q0[0].data;
         req0_amt   = q0[0].amt;
         req0_dir   = q0[0].dir;
      end else begin
         req0_valid = 1'b0;
      end
      @(negedge clk);
      if (req0_valid && req0_ready) begin
         sb.push_back('{1'b0, q0[0].exp, cyc});
         acc_log.push_back(1'b0);
         void'(q0.pop_front());
      end
   end

   // Requester 1 driver.
   initial forever begin
      @(posedge clk);
      #1;
      if (q1.size() != 0) begin
         req1_valid = 1'b1;
         req1_data  = q1[0].data;
         req1_amt   = q1[0].amt;
         req1_dir   = q1[0].dir;
      end else begin
         req1_valid = 1'b0;
      end
      @(negedge clk);
      if (req1_valid && req1_ready) begin
         sb.push_back('{1'b1, q1[0].exp, cyc});
         acc_log.push_back(1'b1);
         void'(q1.pop_front());
      end
   end

   // Response monitor: latency on first sight, stability while held, payload on handshake.
   initial forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
         if (!in_resp) begin
            in_resp = 1'b1;
            held_d  = resp_data;
            held_id = resp_id;
            if (sb.size() == 0) begin
               chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
               chk("latency", 32'(cyc), 32'(sb[0].cyc + 2));
            end
         end else begin
            chk("hold_data", 32'(resp_data), 32'(held_d));
            chk("hold_id", 32'(resp_id), 32'(held_id));
         end
         if (resp_ready && sb.size() != 0) begin
            chk("resp_data", 32'(resp_data), 32'(sb[0].data));
            chk("resp_id", 32'(resp_id), 32'(sb[0].id));
            void'(sb.pop_front());
            in_resp = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string nm, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((q0.size() != 0) || (q1.size() != 0) || (sb.size() != 0) || resp_valid)
                 && (n < budget));
      if (n >= budget) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_acc0(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(req0_valid && req0_ready) && (n < 10));
      if (n >= 10) chk({nm, "_acc_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      // Basic left and right rotates, including the amount-zero wrap.
      q0.push_back('{8'h81, 3'd1, 1'b0, 8'h03});
      wait_idle("t1", 20);
      q1.push_back('{8'h81, 3'd1, 1'b1, 8'hC0});
      q1.push_back('{8'hA5, 3'd0, 1'b1, 8'hA5});
      wait_idle("t2", 30);

      // Both requesters busy: grants must alternate starting with requester 0.
      acc_log.delete();
      q0.push_back('{8'h12, 3'd4, 1'b0, 8'h21});
      q0.push_back('{8'h80, 3'd7, 1'b0, 8'h40});
      q0.push_back('{8'h0F, 3'd2, 1'b1, 8'hC3});
      q1.push_back('{8'h34, 3'd4, 1'b1, 8'h43});
      q1.push_back('{8'h01, 3'd3, 1'b0, 8'h08});
      q1.push_back('{8'hF0, 3'd1, 1'b1, 8'h78});
      wait_idle("t3", 60);
      chk("t3_grants", 32'(acc_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
         chk("t3_grant_order", 32'(acc_log[i]), 32'(i % 2));
      end

      // Back-pressure on the response path.
      resp_ready = 1'b0;
      q0.push_back('{8'h3C, 3'd2, 1'b0, 8'hF0});
      q1.push_back('{8'h55, 3'd1, 1'b0, 8'hAA});
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!resp_valid && (n < 10));
         if (n >= 10) chk("t4_valid_timeout", 32'd1, 32'd0);
      end
      repeat (5) begin
         @(negedge clk);
         chk("t4_ready1_blocked", 32'(req1_ready), 32'd0);
         chk("t4_ready0_blocked", 32'(req0_ready), 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t4_idle_next", 32'(req1_ready), 32'd1);
      wait_idle("t4", 20);

      // Reset while in EXEC.
      q0.push_back('{8'h01, 3'd0, 1'b1, 8'h01});
      wait_idle("t5a", 20);
      chk("t5_rr_before", 32'(dut.rr_ptr), 32'd1);
      q0.push_back('{8'h81, 3'd1, 1'b0, 8'h03});
      wait_acc0("t5_exec");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("t5_exec_valid", 32'(resp_valid), 32'd0);
      chk("t5_exec_rr", 32'(dut.rr_ptr), 32'd0);

      // Reset while in RESP.
      q0.push_back('{8'h80, 3'd0, 1'b0, 8'h80});
      wait_idle("t5b", 20);
      resp_ready = 1'b0;
      q0.push_back('{8'hFF, 3'd5, 1'b1, 8'hFF});
      wait_acc0("t5_resp");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("t5_in_resp", 32'(resp_valid), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      in_resp = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("t5_resp_valid", 32'(resp_valid), 32'd0);
      chk("t5_resp_rr", 32'(dut.rr_ptr), 32'd0);
      chk("t5_resp_data", 32'(resp_data), 32'd0);
      chk("t5_resp_id", 32'(resp_id), 32'd0);

      acc_log.delete();
      q1.push_back('{8'hC3, 3'd3, 1'b0, 8'h1E});
      q0.push_back('{8'h5A, 3'd4, 1'b1, 8'hA5});
      wait_idle("t5c", 30);
      chk("t5_fresh_cnt", 32'(acc_log.size()), 32'd2);
      if (acc_log.size() == 2) begin
         chk("t5_fresh_first", 32'(acc_log[0]), 32'd0);
         chk("t5_fresh_second", 32'(acc_log[1]), 32'd1);
      end

      // Full amount/direction sweep against the reference model.
      for (int a = 0; a < 8; a++) begin
         for (int d = 0; d < 2; d++) begin
            q0.push_back('{8'h01, 3'(a), d[0], ref_rot(8'h01, a, d[0])});
         end
      end
      wait_idle("t6", 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
